chip8_fetch_unit: RTL and testbench
===================================

Name: chip8_fetch_unit

Overview:
- Instruction fetch front end that produces the 16-bit `instruction` word consumed by the CPU decode/execute block.
- Reads two consecutive bytes from byte-wide program memory and assembles them big-endian.
- Presents the word with a valid/ready handshake and owns the fetch program counter.
- Accepts redirects (jump, call, return) and skips from the execute side.

Parameters:
- ADDR_W, 12, program memory address width in bytes (4 KiB Chip-8 space).
- START_PC, 12'h200, fetch address loaded at reset.

Ports:
- cpu_clk  input  1  CPU clock; all state updates on its rising edge.
- cpu_reset_n  input  1  asynchronous, active-low reset.
- mem_addr  output  ADDR_W  byte read address.
- mem_rd  output  1  read strobe; data is returned on mem_rdata exactly one cycle later.
- mem_rdata  input  8  read data byte.
- instruction  output  16  fetched opcode, {byte@pc, byte@pc+1}.
- instr_valid  output  1  instruction and pc are valid.
- instr_ready  input  1  decoder consumes the instruction this cycle.
- pc  output  ADDR_W  address of the presented instruction.
- redirect  input  1  load the fetch PC with redirect_addr.
- redirect_addr  input  ADDR_W  target for jump/call/return.
- skip  input  1  on consume, advance by 4 instead of 2 (3xkk/4xkk/5xy0/Ex9E/ExA1).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - instruction=16'h0000, instr_valid=0, mem_rd=0, mem_addr=0, pc=START_PC.
  - Internal fetch PC (fpc)=START_PC; state=REQ_HI.
- FSM states: REQ_HI, REQ_LO, CAP_LO, VALID.
  - REQ_HI: mem_rd=1, mem_addr=fpc; next state REQ_LO.
  - REQ_LO: hi_byte<=mem_rdata; mem_rd=1, mem_addr=fpc+1; next state CAP_LO.
  - CAP_LO: instruction<={hi_byte,mem_rdata}; pc<=fpc; instr_valid<=1; next state VALID.
  - VALID: hold instruction, pc and instr_valid stable, mem_rd=0, until instr_valid && instr_ready.
- Consume cycle:
  - Redirect asserted: fpc<=redirect_addr.
  - Otherwise, skip asserted: fpc<=pc+4.
  - Otherwise: fpc<=pc+2.
  - In all cases, instr_valid<=0 and next state REQ_HI.
- Latency and throughput:
  - 3 cycles from entering REQ_HI to instr_valid high.
  - Maximum rate is one instruction per 4 cycles with instr_ready tied high.
- mem_rd and mem_addr are registered outputs; mem_addr holds its last value when mem_rd=0.
- Redirect outside a consume cycle (REQ_HI, REQ_LO, CAP_LO, or VALID with instr_ready=0):
  - Abort the in-flight fetch and set fpc<=redirect_addr.
  - Drop instr_valid the next cycle and go to REQ_HI.
  - Data returning for the aborted read is discarded.
- Redirect has priority over skip.
- skip is ignored outside a consume cycle.
- Arithmetic is modulo 2^ADDR_W:
  - fpc+1 from 12'hFFF reads 12'h000.
  - pc+2 and pc+4 wrap the same way.
- Odd addresses are legal: no alignment is forced, and bytes are fetched exactly at fpc and fpc+1.
- instr_ready while instr_valid=0 has no effect.
- Reset asserted mid-fetch: everything returns to reset values immediately, and fetch restarts at START_PC in REQ_HI after release.

Test Plan:
- Reset release, memory 0x200=8'h6A, 0x201=8'h05, instr_ready=1:
  - mem_rd high at cycles 0 and 1 with addresses 0x200, 0x201.
  - Cycle 3: instr_valid=1, instruction=16'h6A05, pc=0x200.
  - Next fetch address 0x202.
- instr_ready=0 for 10 cycles with a valid instruction presented:
  - instruction and pc stay stable and mem_rd stays 0.
  - Raise ready: consumed in one cycle, next fetch starts at pc+2.
- Consume 0x204 with skip=1: next fetch address 0x208.
- Consume 0x204 with skip=1 and redirect=1, redirect_addr=0x300: next fetch 0x300 (redirect wins).
- Redirect to 0x400 while in REQ_LO:
  - Abort; next mem_addr=0x400.
  - The first instr_valid carries {mem[0x400],mem[0x401]}, pc=0x400; no stale word is presented.
- Wrap and reset:
  - redirect_addr=0xFFF, mem[0xFFF]=8'h12, mem[0x000]=8'h34: instruction=16'h1234; consume gives next fetch 0x001.
  - cpu_reset_n pulsed low during CAP_LO: instr_valid=0 and pc=0x200 immediately, and fetch restarts at 0x200.

Source files
------------

// File: rtl/chip8_fetch_unit.sv
// Chip-8 fetch: reads {mem[fpc], mem[fpc+1]} and presents the opcode with valid/ready; 3 cycles REQ_HI->valid.
// Holds the word until consumed; redirect aborts any in-flight fetch; mem_rd/mem_addr are registered.
module chip8_fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] START_PC = 12'h200
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              skip
);

    typedef enum logic [1:0] {
        REQ_HI,
        REQ_LO,
        CAP_LO,
        VALID
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] fpc_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [7:0]        hi_byte;
    logic              hi_load;
    logic              lo_capture;

    always_comb begin
        state_next = state;
        fpc_next   = fpc;
        hi_load    = 1'b0;
        lo_capture = 1'b0;
        case (state)
            // Out of reset the strobe is still low, so REQ_HI spends one cycle raising it.
            REQ_HI:  state_next = mem_rd ? REQ_LO : REQ_HI;
            REQ_LO: begin
                hi_load    = 1'b1;
                state_next = CAP_LO;
            end
            CAP_LO: begin
                lo_capture = 1'b1;
                state_next = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    state_next = REQ_HI;
                    fpc_next   = skip ? pc + ADDR_W'(4) : pc + ADDR_W'(2);
                end
            end
            default: state_next = REQ_HI;
        endcase
        // Redirect wins everywhere; the read already in flight is simply never captured.
        if (redirect) begin
            state_next = REQ_HI;
            fpc_next   = redirect_addr;
            hi_load    = 1'b0;
            lo_capture = 1'b0;
        end
    end

    always_comb begin
        mem_addr_next = mem_addr;
        case (state_next)
            REQ_HI:  mem_addr_next = fpc_next;
            REQ_LO:  mem_addr_next = fpc_next + ADDR_W'(1);
            default: mem_addr_next = mem_addr;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state       <= REQ_HI;
            fpc         <= START_PC;
            hi_byte     <= 8'h00;
            instruction <= 16'h0000;
            instr_valid <= 1'b0;
            pc          <= START_PC;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state       <= state_next;
            fpc         <= fpc_next;
            instr_valid <= (state_next == VALID);
            mem_rd      <= (state_next == REQ_HI) || (state_next == REQ_LO);
            mem_addr    <= mem_addr_next;
            if (hi_load) begin
                hi_byte <= mem_rdata;
            end
            if (lo_capture) begin
                instruction <= {hi_byte, mem_rdata};
                pc          <= fpc;
            end
        end
    end

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// Directed bench for chip8_fetch_unit with a one-cycle-latency byte memory model.
module tb_chip8_fetch_unit;

    logic        cpu_clk;
    logic        cpu_reset_n;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] pc;
    logic        redirect;
    logic [11:0] redirect_addr;
    logic        skip;

    logic [7:0]  mem [0:4095];
    int          total;
    int          bad;

    chip8_fetch_unit #(.ADDR_W(12), .START_PC(12'h200)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_reset_n   (cpu_reset_n),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .skip          (skip)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic consume(input logic skp, input logic rdr, input logic [11:0] raddr);
        instr_ready   = 1'b1;
        skip          = skp;
        redirect      = rdr;
        redirect_addr = raddr;
        step();
        instr_ready   = 1'b0;
        skip          = 1'b0;
        redirect      = 1'b0;
    endtask

    initial begin
        int n;
        total         = 0;
        bad           = 0;
        cpu_reset_n   = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 12'h000;
        skip          = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'(i * 7 + 3);
        end
        mem[12'h200] = 8'h6A;
        mem[12'h201] = 8'h05;
        mem[12'h400] = 8'hA1;
        mem[12'h401] = 8'hB2;
        mem[12'hFFF] = 8'h12;
        mem[12'h000] = 8'h34;

        step();
        step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h000);
        chk("rst_pc", 32'(pc), 32'h200);
        chk("rst_instr", 32'(instruction), 32'h0000);

        cpu_reset_n = 1'b1;
        n = 0;
        while (mem_rd !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("c0_mem_rd", 32'(mem_rd), 32'd1);
        chk("c0_addr", 32'(mem_addr), 32'h200);
        step();
        chk("c1_mem_rd", 32'(mem_rd), 32'd1);
        chk("c1_addr", 32'(mem_addr), 32'h201);
        step();
        chk("c2_mem_rd", 32'(mem_rd), 32'd0);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        step();
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", 32'(instruction), 32'h6A05);
        chk("c3_pc", 32'(pc), 32'h200);

        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", 32'(instruction), 32'h6A05);
            chk("hold_pc", 32'(pc), 32'h200);
            chk("hold_mem_rd", 32'(mem_rd), 32'd0);
        end

        consume(1'b0, 1'b0, 12'h000);
        chk("cons_valid_drop", 32'(instr_valid), 32'd0);
        chk("cons_mem_rd", 32'(mem_rd), 32'd1);
        chk("cons_next_addr", 32'(mem_addr), 32'h202);

        wait_valid("w202");
        chk("pc202", 32'(pc), 32'h202);
        consume(1'b0, 1'b0, 12'h000);
        chk("next_204", 32'(mem_addr), 32'h204);

        wait_valid("w204");
        chk("pc204", 32'(pc), 32'h204);
        consume(1'b1, 1'b0, 12'h000);
        chk("skip_208", 32'(mem_addr), 32'h208);

        wait_valid("w208");
        redirect      = 1'b1;
        redirect_addr = 12'h204;
        step();
        redirect      = 1'b0;
        chk("rdr_valid_drop", 32'(instr_valid), 32'd0);
        chk("rdr_addr_204", 32'(mem_addr), 32'h204);

        wait_valid("w204b");
        chk("pc204b", 32'(pc), 32'h204);
        consume(1'b1, 1'b1, 12'h300);
        chk("rdr_wins_300", 32'(mem_addr), 32'h300);

        wait_valid("w300");
        chk("pc300", 32'(pc), 32'h300);
        consume(1'b0, 1'b0, 12'h000);
        chk("next_302", 32'(mem_addr), 32'h302);
        step();
        chk("reqlo_303", 32'(mem_addr), 32'h303);
        redirect      = 1'b1;
        redirect_addr = 12'h400;
        step();
        redirect      = 1'b0;
        chk("abort_addr", 32'(mem_addr), 32'h400);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        wait_valid("w400");
        chk("pc400", 32'(pc), 32'h400);
        chk("instr400", 32'(instruction), 32'hA1B2);

        redirect      = 1'b1;
        redirect_addr = 12'hFFF;
        step();
        redirect      = 1'b0;
        chk("wrap_hi_addr", 32'(mem_addr), 32'hFFF);
        step();
        step();
        chk("wrap_lo_addr", 32'(mem_addr), 32'h000);
        wait_valid("wFFF");
        chk("pcFFF", 32'(pc), 32'hFFF);
        chk("instrFFF", 32'(instruction), 32'h1234);
        consume(1'b0, 1'b0, 12'h000);
        chk("wrap_next_001", 32'(mem_addr), 32'h001);

        step();
        step();
        cpu_reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_pc", 32'(pc), 32'h200);
        chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
        step();
        cpu_reset_n = 1'b1;
        n = 0;
        while (mem_rd !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("restart_addr", 32'(mem_addr), 32'h200);
        wait_valid("wrestart");
        chk("restart_pc", 32'(pc), 32'h200);
        chk("restart_instr", 32'(instruction), 32'h6A05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
